// File: rtl/data_mem_ctrl_pkg.sv
// Shared types and helpers for the data-memory access stage.
//   size_t  : access width decoded from the core's 2-bit size field
//   state_t : access FSM states
//   BE_*    : byte-enable patterns (little-endian lanes)
package data_mem_ctrl_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_t;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] BE_BYTE    = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    // Encodings 10 and 11 both mean a word access.
    function automatic size_t decode_size(input logic [1:0] s);
        case (s)
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: return 1'b1;
            SZ_HALF: return ~a[0];
            default: return (a == 2'b00);
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input size_t sz, input logic [1:0] a);
        case (sz)
            SZ_BYTE: return BE_BYTE << a;
            SZ_HALF: return a[1] ? BE_HALF_HI : BE_HALF_LO;
            default: return BE_WORD;
        endcase
    endfunction

    // Store data is replicated across lanes so the byte enables alone pick the target.
    function automatic logic [31:0] lane_wdata(input size_t sz, input logic [31:0] wd);
        case (sz)
            SZ_BYTE: return {4{wd[7:0]}};
            SZ_HALF: return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Variable-latency memory bus: req/gnt/rvalid handshake.
//   master : access controller (drives request fields, receives gnt/rvalid/rdata)
//   slave  : memory side
interface data_mem_ctrl_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/data_mem_ctrl_load_align.sv
// Load lane selection and extension.
//   rdata    : raw 32-bit bus word
//   addr_lo  : byte offset of the access
//   size     : access width
//   sign_ext : 1 sign-extends byte/half, 0 zero-extends; ignored for words
//   value    : 32-bit result for write-back
module data_mem_ctrl_load_align
    import data_mem_ctrl_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr_lo,
    input  size_t       size,
    input  logic        sign_ext,
    output logic [31:0] value
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        case (addr_lo)
            2'b00:   byte_lane = rdata[7:0];
            2'b01:   byte_lane = rdata[15:8];
            2'b10:   byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (size)
            SZ_BYTE: value = {{24{sign_ext & byte_lane[7]}}, byte_lane};
            SZ_HALF: value = {{16{sign_ext & half_lane[15]}}, half_lane};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory access stage between the single-cycle datapath and a
// variable-latency bus. Stalls the core until each load/store completes.
//   clk, rst                 : clock, synchronous active-high reset
//   mem_read, mem_write      : access request (store wins if both set)
//   size, sign_ext           : access width and load extension
//   addr, write_data         : byte address and store operand
//   read_data                : load result, held until the next completed load
//   stall                    : core holds PC/regs while high
//   misaligned               : request rejected, no bus activity
//   bus_err                  : one-cycle pulse when an access is ended by timeout
//   bus                      : memory bus (master side)
// TIMEOUT: max cycles in REQ+WAIT before forced completion; 0 disables.
module data_mem_ctrl
    import data_mem_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic [1:0]         size,
    input  logic               sign_ext,
    input  logic [31:0]        addr,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               stall,
    output logic               misaligned,
    output logic               bus_err,
    data_mem_ctrl_if.master    bus
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t        state;
    size_t         req_size;
    size_t         cur_size;
    logic          cur_sign;
    logic [1:0]    cur_lo;
    logic [CW-1:0] to_cnt;
    logic [31:0]   load_value;
    logic          req_any;
    logic          req_ok;
    logic          timed_out;

    always_comb begin
        req_size   = decode_size(size);
        req_any    = mem_read | mem_write;
        req_ok     = is_aligned(req_size, addr[1:0]);
        timed_out  = (TIMEOUT != 0) && (to_cnt == TO_LAST);
        stall      = 1'b0;
        misaligned = 1'b0;
        case (state)
            IDLE: begin
                stall      = req_any & req_ok;
                misaligned = req_any & ~req_ok;
            end
            REQ, WAIT: stall = 1'b1;
            default:   stall = 1'b0;
        endcase
    end

    data_mem_ctrl_load_align u_align (
        .rdata    (bus.bus_rdata),
        .addr_lo  (cur_lo),
        .size     (cur_size),
        .sign_ext (cur_sign),
        .value    (load_value)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            read_data     <= '0;
            bus_err       <= 1'b0;
            to_cnt        <= '0;
            cur_size      <= SZ_BYTE;
            cur_sign      <= 1'b0;
            cur_lo        <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_we    <= 1'b0;
            bus.bus_addr  <= '0;
            bus.bus_be    <= '0;
            bus.bus_wdata <= '0;
        end else begin
            bus_err <= 1'b0;
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (req_any && req_ok) begin
                        bus.bus_req   <= 1'b1;
                        bus.bus_we    <= mem_write;
                        bus.bus_addr  <= {addr[31:2], 2'b00};
                        bus.bus_be    <= byte_enables(req_size, addr[1:0]);
                        bus.bus_wdata <= lane_wdata(req_size, write_data);
                        cur_size      <= req_size;
                        cur_sign      <= sign_ext;
                        cur_lo        <= addr[1:0];
                        state         <= REQ;
                    end
                end
                // A handshake on the final allowed cycle still completes normally.
                REQ: begin
                    if (bus.bus_gnt) begin
                        bus.bus_req <= 1'b0;
                        if (bus.bus_we) begin
                            to_cnt <= '0;
                            state  <= DONE;
                        end else if (bus.bus_rvalid) begin
                            read_data <= load_value;
                            to_cnt    <= '0;
                            state     <= DONE;
                        end else begin
                            to_cnt <= to_cnt + CW'(1);
                            state  <= WAIT;
                        end
                    end else if (timed_out) begin
                        bus.bus_req <= 1'b0;
                        bus_err     <= 1'b1;
                        to_cnt      <= '0;
                        state       <= DONE;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                WAIT: begin
                    if (bus.bus_rvalid) begin
                        read_data <= load_value;
                        to_cnt    <= '0;
                        state     <= DONE;
                    end else if (timed_out) begin
                        bus_err <= 1'b1;
                        to_cnt  <= '0;
                        state   <= DONE;
                    end else begin
                        to_cnt <= to_cnt + CW'(1);
                    end
                end
                default: begin
                    to_cnt <= '0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Self-checking bench for data_mem_ctrl. Two instances: the default-timeout
// controller for normal traffic and a TIMEOUT=4 controller for forced completion.
module tb_data_mem_ctrl;

    localparam int TO = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        mem_read, mem_write, sign_ext;
    logic [1:0]  size;
    logic [31:0] addr, write_data;
    logic        use_to;
    logic        tb_gnt, tb_rvalid;
    logic [31:0] tb_rdata;

    logic [31:0] rd_m, rd_t;
    logic        stall_m, stall_t, mis_m, mis_t, err_m, err_t;

    data_mem_ctrl_if bus_m ();
    data_mem_ctrl_if bus_t ();

    assign bus_m.bus_gnt    = tb_gnt & ~use_to;
    assign bus_m.bus_rvalid = tb_rvalid & ~use_to;
    assign bus_m.bus_rdata  = tb_rdata;
    assign bus_t.bus_gnt    = tb_gnt & use_to;
    assign bus_t.bus_rvalid = tb_rvalid & use_to;
    assign bus_t.bus_rdata  = tb_rdata;

    data_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read & ~use_to),
        .mem_write  (mem_write & ~use_to),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (rd_m),
        .stall      (stall_m),
        .misaligned (mis_m),
        .bus_err    (err_m),
        .bus        (bus_m)
    );

    data_mem_ctrl #(.TIMEOUT(TO)) dut_to (
        .clk        (clk),
        .rst        (rst),
        .mem_read   (mem_read & use_to),
        .mem_write  (mem_write & use_to),
        .size       (size),
        .sign_ext   (sign_ext),
        .addr       (addr),
        .write_data (write_data),
        .read_data  (rd_t),
        .stall      (stall_t),
        .misaligned (mis_t),
        .bus_err    (err_t),
        .bus        (bus_t)
    );

    // Observed outputs of whichever instance is under test.
    logic        o_stall, o_mis, o_err, o_req, o_we;
    logic [31:0] o_rd, o_addr, o_wdata;
    logic [3:0]  o_be;
    assign o_stall = use_to ? stall_t : stall_m;
    assign o_mis   = use_to ? mis_t : mis_m;
    assign o_err   = use_to ? err_t : err_m;
    assign o_rd    = use_to ? rd_t : rd_m;
    assign o_req   = use_to ? bus_t.bus_req : bus_m.bus_req;
    assign o_we    = use_to ? bus_t.bus_we : bus_m.bus_we;
    assign o_addr  = use_to ? bus_t.bus_addr : bus_m.bus_addr;
    assign o_be    = use_to ? bus_t.bus_be : bus_m.bus_be;
    assign o_wdata = use_to ? bus_t.bus_wdata : bus_m.bus_wdata;

    typedef struct {
        string       tag;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic        err;
        int          stall_cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] exp_rd [2];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model of lane behaviour.
    function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
        case (sz)
            2'b00:   return 4'b0001 << a;
            2'b01:   return a[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] wd);
        case (sz)
            2'b00:   return {4{wd[7:0]}};
            2'b01:   return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] rdata, input logic [1:0] a,
                                           input logic [1:0] sz, input logic se);
        logic [31:0] s;
        case (sz)
            2'b00: begin
                s = rdata >> (8 * a);
                return (se && s[7]) ? (s | 32'hFFFF_FF00) : (s & 32'h0000_00FF);
            end
            2'b01: begin
                s = a[1] ? (rdata >> 16) : rdata;
                return (se && s[15]) ? (s | 32'hFFFF_0000) : (s & 32'h0000_FFFF);
            end
            default: return rdata;
        endcase
    endfunction

    // One access on instance inst; gnt_wait<0 means the bus never grants.
    task automatic run_txn(input string tag, input int inst, input logic we,
                           input logic [1:0] sz, input logic se,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int gnt_wait, input int rv_wait, input logic [31:0] rdata);
        exp_t        e;
        exp_t        got;
        logic        o_we_c;
        logic [31:0] o_addr_c, o_wdata_c;
        logic [3:0]  o_be_c;
        int          n_stall, n_req, since;
        bit          gnt_done, captured, done;

        e.tag   = tag;
        e.we    = we;
        e.addr  = {a[31:2], 2'b00};
        e.be    = m_be(sz, a[1:0]);
        e.wdata = m_wdata(sz, wd);
        if (gnt_wait < 0) begin
            e.err = 1'b1;
            e.rd  = exp_rd[inst];
            e.stall_cyc = 1 + TO;
        end else if (we) begin
            e.err = 1'b0;
            e.rd  = exp_rd[inst];
            e.stall_cyc = 2 + gnt_wait;
        end else begin
            e.err = 1'b0;
            e.rd  = m_load(rdata, a[1:0], sz, se);
            e.stall_cyc = 2 + gnt_wait + rv_wait;
        end
        exp_rd[inst] = e.rd;
        sb.push_back(e);

        @(negedge clk);
        use_to     = (inst == 1);
        mem_write  = we;
        mem_read   = ~we;
        size       = sz;
        sign_ext   = se;
        addr       = a;
        write_data = wd;
        tb_rdata   = rdata;
        n_stall = 0; n_req = 0; since = 0;
        gnt_done = 0; captured = 0; done = 0;
        o_we_c = 1'b0; o_addr_c = '0; o_wdata_c = '0; o_be_c = '0;

        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            tb_gnt    = 1'b0;
            tb_rvalid = 1'b0;
            if (o_req && !gnt_done && gnt_wait >= 0 && n_req == gnt_wait) begin
                tb_gnt   = 1'b1;
                gnt_done = 1;
                since    = 0;
            end
            if (!we && gnt_done && since == rv_wait) tb_rvalid = 1'b1;
            if (gnt_done) since++;
            if (o_req && !captured) begin
                captured  = 1;
                o_we_c    = o_we;
                o_addr_c  = o_addr;
                o_be_c    = o_be;
                o_wdata_c = o_wdata;
            end
            if (o_req) n_req++;
            #1;
            if (cyc == 0) check_eq({tag, "_mis"}, 32'(o_mis), 32'd0);
            if (o_stall) begin
                n_stall++;
            end else if (cyc > 0) begin
                done = 1;
                got  = sb.pop_front();
                check_eq({got.tag, "_stall_cycles"}, n_stall, got.stall_cyc);
                check_eq({got.tag, "_read_data"}, o_rd, got.rd);
                check_eq({got.tag, "_bus_err"}, 32'(o_err), 32'(got.err));
                check_eq({got.tag, "_req_low"}, 32'(o_req), 32'd0);
                check_eq({got.tag, "_we"}, 32'(o_we_c), 32'(got.we));
                check_eq({got.tag, "_addr"}, o_addr_c, got.addr);
                check_eq({got.tag, "_be"}, 32'(o_be_c), 32'(got.be));
                if (got.we) check_eq({got.tag, "_wdata"}, o_wdata_c, got.wdata);
                if (gnt_wait < 0) check_eq({got.tag, "_req_cycles"}, n_req, TO);
            end
        end
        if (!done) begin
            check_eq({tag, "_complete"}, 32'd0, 32'd1);
            void'(sb.pop_front());
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        tb_gnt    = 1'b0;
        tb_rvalid = 1'b0;
    endtask

    task automatic check_mis(input string tag, input logic we, input logic [1:0] sz,
                             input logic [31:0] a);
        @(negedge clk);
        use_to    = 1'b0;
        mem_write = we;
        mem_read  = ~we;
        size      = sz;
        addr      = a;
        #1;
        check_eq({tag, "_mis"}, 32'(o_mis), 32'd1);
        check_eq({tag, "_stall"}, 32'(o_stall), 32'd0);
        check_eq({tag, "_req"}, 32'(o_req), 32'd0);
        @(negedge clk);
        #1;
        check_eq({tag, "_req_next"}, 32'(o_req), 32'd0);
        check_eq({tag, "_read_data"}, o_rd, exp_rd[0]);
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; sign_ext = 1'b0;
        size = 2'b00; addr = '0; write_data = '0; use_to = 1'b0;
        tb_gnt = 1'b0; tb_rvalid = 1'b0; tb_rdata = '0;
        exp_rd[0] = '0; exp_rd[1] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check_eq("rst_read_data", o_rd, 32'd0);
        check_eq("rst_stall", 32'(o_stall), 32'd0);
        check_eq("rst_req", 32'(o_req), 32'd0);
        check_eq("rst_err", 32'(o_err), 32'd0);
        check_eq("rst_addr", o_addr, 32'd0);
        check_eq("rst_be", 32'(o_be), 32'd0);

        run_txn("sw_100", 0, 1'b1, 2'b10, 1'b0, 32'h100, 32'h1234_5678, 0, 0, '0);
        run_txn("lb_203_s", 0, 1'b0, 2'b00, 1'b1, 32'h203, '0, 2, 3, 32'h80FF_FFFF);
        run_txn("lb_203_u", 0, 1'b0, 2'b00, 1'b0, 32'h203, '0, 2, 3, 32'h80FF_FFFF);
        run_txn("sh_42", 0, 1'b1, 2'b01, 1'b0, 32'h42, 32'h0000_BEEF, 1, 0, '0);
        run_txn("lhu_42", 0, 1'b0, 2'b01, 1'b0, 32'h42, '0, 0, 0, 32'hBEEF_0000);
        for (int i = 0; i < 4; i++) begin
            run_txn($sformatf("lb_lane%0d", i), 0, 1'b0, 2'b00, i[0], 32'h500 + i,
                    '0, i % 2, i, 32'h7F80_C311);
            run_txn($sformatf("sb_lane%0d", i), 0, 1'b1, 2'b00, 1'b0, 32'h600 + i,
                    32'h0000_00A5 + i, i, 0, '0);
        end
        run_txn("lh_lo_s", 0, 1'b0, 2'b01, 1'b1, 32'h700, '0, 0, 1, 32'h1234_8001);
        run_txn("lw_se", 0, 1'b0, 2'b11, 1'b1, 32'h704, '0, 1, 1, 32'h8765_4321);

        check_mis("lw_6", 1'b0, 2'b10, 32'h6);
        check_mis("sh_1", 1'b1, 2'b01, 32'h1);

        run_txn("to_lw_ok", 1, 1'b0, 2'b10, 1'b0, 32'h800, '0, 0, 1, 32'hCAFE_F00D);
        run_txn("to_lw_tmo", 1, 1'b0, 2'b10, 1'b0, 32'h804, '0, -1, 0, '0);
        @(negedge clk);
        #1;
        check_eq("to_err_pulse", 32'(o_err), 32'd0);
        check_eq("to_stall_idle", 32'(o_stall), 32'd0);

        // Reset while a load waits for rvalid; the late rvalid must be ignored.
        @(negedge clk);
        use_to = 1'b0; mem_read = 1'b1; size = 2'b10; addr = 32'h300;
        @(negedge clk);
        tb_gnt = 1'b1;
        @(negedge clk);
        tb_gnt = 1'b0;
        #1;
        check_eq("rstw_in_wait", 32'(o_stall), 32'd1);
        rst = 1'b1; mem_read = 1'b0;
        @(negedge clk);
        rst = 1'b0; tb_rvalid = 1'b1; tb_rdata = 32'hDEAD_BEEF;
        exp_rd[0] = '0;
        #1;
        check_eq("rstw_stall", 32'(o_stall), 32'd0);
        check_eq("rstw_read_data", o_rd, 32'd0);
        check_eq("rstw_req", 32'(o_req), 32'd0);
        @(negedge clk);
        tb_rvalid = 1'b0;
        #1;
        check_eq("rstw_late_rvalid", o_rd, 32'd0);
        check_eq("rstw_late_stall", 32'(o_stall), 32'd0);

        run_txn("b2b_sw", 0, 1'b1, 2'b10, 1'b0, 32'h400, 32'hA5A5_0F0F, 0, 0, '0);
        run_txn("b2b_lw", 0, 1'b0, 2'b10, 1'b0, 32'h400, '0, 0, 0, 32'hA5A5_0F0F);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
